// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: ID->EX issue scheduler for the in-order RV32 core.
// Tracks in-flight register writes, stalls decode on RAW hazards,
// serialises CSR/ecall/mret and sequences the flush after an EX redirect.
// Optional build macro HAZARD_PERF_EN adds stall/flush/drain perf counters.
module pipe_hazard_ctrl #(
    parameter int unsigned  CNT_W        = 2,
    parameter int unsigned  MAX_INFLIGHT = 3,
    parameter int unsigned  FLUSH_CYCLES = 2,
    localparam int unsigned INF_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_rd_wen,
    input  logic             id_serial,
    input  logic             ex_ready,
    output logic             issue,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             wb_wen,
    input  logic             ex_redirect,
    output logic             pipe_stop,
    output logic             inst_clear,
    output logic [INF_W-1:0] inflight,
    output logic             busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      perf_raw_stall,
    output logic [31:0]      perf_flush,
    output logic [31:0]      perf_drain
`endif
);

    localparam int unsigned NREG = 32;
    localparam int unsigned FC_W = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [FC_W-1:0]   flush_cnt;
    logic [FC_W-1:0]   flush_cnt_next;

    // Entry 0 is never written, so x0 always reads as "no pending write"
    logic [CNT_W-1:0]  cnt [NREG];
    logic [NREG-1:0]   cnt_inc;
    logic [NREG-1:0]   cnt_dec;

    logic              rs1_pending;
    logic              rs2_pending;
    logic              hazard;
    logic              rd_full;
    logic              pipe_full;
    logic              serial_wait;
    logic              block;
    logic              inf_inc;
    logic              inf_dec;
    logic              drain_done;

    // Hazard and blocking terms, all from registered scoreboard state
    assign rs1_pending = id_use_rs1 & (id_rs1 != 5'd0) & (cnt[id_rs1] != '0);
    assign rs2_pending = id_use_rs2 & (id_rs2 != 5'd0) & (cnt[id_rs2] != '0);
    assign hazard      = rs1_pending | rs2_pending;
    assign rd_full     = id_rd_wen & (id_rd != 5'd0) & (cnt[id_rd] == {CNT_W{1'b1}});
    assign pipe_full   = (inflight == INF_W'(MAX_INFLIGHT));
    assign serial_wait = id_serial & (inflight != '0);
    assign block       = hazard | pipe_full | rd_full | serial_wait;

    // Drain finishes once the last in-flight instruction retires
    assign drain_done  = (inflight == '0) | ((inflight == INF_W'(1)) & wb_valid);

    assign busy        = (state != ST_RUN);

    // State and flush down-counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    // Next-state, issue and decode-hold decisions
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        issue          = 1'b0;
        pipe_stop      = 1'b0;
        case (state)
            ST_RUN: begin
                issue     = id_valid & ex_ready & ~block & ~ex_redirect;
                pipe_stop = id_valid & ~issue;
                if (ex_redirect) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = FC_W'(FLUSH_CYCLES - 1);
                end else if (id_valid & serial_wait) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                pipe_stop = 1'b1;
                if (ex_redirect) begin
                    flush_cnt_next = FC_W'(FLUSH_CYCLES - 1);
                end else if (flush_cnt == '0) begin
                    state_next = ST_RUN;
                end else begin
                    flush_cnt_next = flush_cnt - FC_W'(1);
                end
            end
            ST_DRAIN: begin
                pipe_stop = 1'b1;
                if (ex_redirect) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = FC_W'(FLUSH_CYCLES - 1);
                end else if (drain_done) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Squash pulse tracks the registered FLUSH state
    always_ff @(posedge clock) begin
        if (reset) begin
            inst_clear <= 1'b0;
        end else begin
            inst_clear <= (state_next == ST_FLUSH);
        end
    end

    // Per-register increment/decrement requests; retire on an idle counter is ignored
    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        if (issue & id_rd_wen & (id_rd != 5'd0)) begin
            cnt_inc[id_rd] = 1'b1;
        end
        if (wb_valid & wb_wen & (wb_rd != 5'd0) & (cnt[wb_rd] != '0)) begin
            cnt_dec[wb_rd] = 1'b1;
        end
    end

    // Scoreboard counters; simultaneous issue and retire cancel
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (cnt_inc[r] & ~cnt_dec[r]) begin
                    cnt[r] <= cnt[r] + CNT_W'(1);
                end else if (cnt_dec[r] & ~cnt_inc[r]) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
        end
    end

    assign inf_inc = issue;
    assign inf_dec = wb_valid & (inflight != '0);

    // Total in-flight count, saturating at zero on a stray retire
    always_ff @(posedge clock) begin
        if (reset) begin
            inflight <= '0;
        end else if (inf_inc & ~inf_dec) begin
            inflight <= inflight + INF_W'(1);
        end else if (inf_dec & ~inf_inc) begin
            inflight <= inflight - INF_W'(1);
        end
    end

`ifdef HAZARD_PERF_EN
    // Performance counters, free-running and wrapping
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_raw_stall <= '0;
            perf_flush     <= '0;
            perf_drain     <= '0;
        end else begin
            if (id_valid & hazard & (state == ST_RUN)) begin
                perf_raw_stall <= perf_raw_stall + 32'd1;
            end
            if (ex_redirect) begin
                perf_flush <= perf_flush + 32'd1;
            end
            if (state == ST_DRAIN) begin
                perf_drain <= perf_drain + 32'd1;
            end
        end
    end
`else
    // Performance counters are not built in this configuration
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: RAW stall, x0, full pipe,
// serialisation, redirect flush and reset mid-flush.
module tb_pipe_hazard_ctrl;

    logic       clock;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] id_rd;
    logic       id_rd_wen;
    logic       id_serial;
    logic       ex_ready;
    logic       issue;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       wb_wen;
    logic       ex_redirect;
    logic       pipe_stop;
    logic       inst_clear;
    logic [1:0] inflight;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    pipe_hazard_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_rd_wen   (id_rd_wen),
        .id_serial   (id_serial),
        .ex_ready    (ex_ready),
        .issue       (issue),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_wen      (wb_wen),
        .ex_redirect (ex_redirect),
        .pipe_stop   (pipe_stop),
        .inst_clear  (inst_clear),
        .inflight    (inflight),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare every observable output of the current cycle
    task automatic chk_out(input string tag, input logic iss, input logic stop,
                           input logic clr, input logic bsy, input logic [1:0] inf);
        check({tag, ".issue"},      32'(issue),      32'(iss));
        check({tag, ".pipe_stop"},  32'(pipe_stop),  32'(stop));
        check({tag, ".inst_clear"}, 32'(inst_clear), 32'(clr));
        check({tag, ".busy"},       32'(busy),       32'(bsy));
        check({tag, ".inflight"},   32'(inflight),   32'(inf));
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic wen, input logic ser);
        id_valid   = v;
        id_rs1     = rs1;
        id_use_rs1 = u1;
        id_rs2     = rs2;
        id_use_rs2 = u2;
        id_rd      = rd;
        id_rd_wen  = wen;
        id_serial  = ser;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd, input logic wen);
        wb_valid = v;
        wb_rd    = rd;
        wb_wen   = wen;
    endtask

    // Advance one cycle; inputs are changed and outputs read away from the edge
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        ex_ready    = 1'b1;
        ex_redirect = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0, 0);
        tick; tick;
        reset = 1'b0;
        settle;
        chk_out("rst", 0, 0, 0, 0, 2'd0);

        // RAW stall on x5
        set_id(1, 0, 0, 0, 0, 5'd5, 1, 0); settle;
        chk_out("raw_prod", 1, 0, 0, 0, 2'd0); tick;
        set_id(1, 5'd5, 1, 0, 0, 5'd6, 1, 0); settle;
        chk_out("raw_st1", 0, 1, 0, 0, 2'd1); tick;
        settle;
        chk_out("raw_st2", 0, 1, 0, 0, 2'd1); tick;
        set_wb(1, 5'd5, 1); settle;
        chk_out("raw_wb", 0, 1, 0, 0, 2'd1); tick;
        set_wb(0, 0, 0); settle;
        chk_out("raw_rel", 1, 0, 0, 0, 2'd0); tick;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(1, 5'd6, 1); settle;
        chk_out("raw_ret6", 0, 0, 0, 0, 2'd1); tick;
        set_wb(0, 0, 0);

        // x5/x6 clear again; x0 never stalls nor counts
        set_id(1, 5'd5, 1, 5'd6, 1, 5'd0, 1, 0); settle;
        chk_out("x0_a", 1, 0, 0, 0, 2'd0); tick;
        set_id(1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 0); settle;
        chk_out("x0_b", 1, 0, 0, 0, 2'd1); tick;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(1, 5'd0, 1); settle;
        chk_out("x0_c", 0, 0, 0, 0, 2'd2); tick;
        settle;
        chk_out("x0_d", 0, 0, 0, 0, 2'd1); tick;
        set_wb(0, 0, 0);

        // Full pipe
        for (int i = 1; i <= 3; i++) begin
            set_id(1, 0, 0, 0, 0, 5'(i), 1, 0); settle;
            chk_out($sformatf("fill%0d", i), 1, 0, 0, 0, 2'(i - 1)); tick;
        end
        set_id(1, 0, 0, 0, 0, 5'd4, 1, 0); settle;
        chk_out("full_st", 0, 1, 0, 0, 2'd3); tick;
        set_wb(1, 5'd1, 1); settle;
        chk_out("full_wb", 0, 1, 0, 0, 2'd3); tick;
        set_wb(1, 5'd2, 1); settle;
        chk_out("full_rel", 1, 0, 0, 0, 2'd2); tick;
        set_wb(0, 0, 0);
        set_id(1, 0, 0, 0, 0, 5'd2, 1, 0); settle;
        chk_out("same_cyc", 1, 0, 0, 0, 2'd2); tick;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(1, 5'd3, 1); settle;
        chk_out("full3", 0, 0, 0, 0, 2'd3); tick;
        set_wb(0, 0, 0);

        // Serialisation with two in flight (x4, x2)
        set_id(1, 0, 0, 0, 0, 0, 0, 1); settle;
        chk_out("ser_req", 0, 1, 0, 0, 2'd2); tick;
        set_wb(1, 5'd4, 1); settle;
        chk_out("drain1", 0, 1, 0, 1, 2'd2); tick;
        set_wb(1, 5'd2, 1); settle;
        chk_out("drain2", 0, 1, 0, 1, 2'd1); tick;
        set_wb(0, 0, 0); settle;
        chk_out("ser_iss", 1, 0, 0, 0, 2'd0); tick;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(1, 0, 0); settle;
        chk_out("ser_done", 0, 0, 0, 0, 2'd1); tick;
        set_wb(0, 0, 0);

        // Redirect with one instruction in flight
        set_id(1, 0, 0, 0, 0, 5'd9, 1, 0); settle;
        chk_out("rd_pre", 1, 0, 0, 0, 2'd0); tick;
        set_id(1, 0, 0, 0, 0, 5'd10, 1, 0);
        ex_redirect = 1'b1; settle;
        chk_out("redir", 0, 1, 0, 0, 2'd1); tick;
        ex_redirect = 1'b0;
        set_wb(1, 5'd9, 1); settle;
        chk_out("flush1", 0, 1, 1, 1, 2'd1); tick;
        set_wb(0, 0, 0); settle;
        chk_out("flush2", 0, 1, 1, 1, 2'd0); tick;
        set_id(0, 0, 0, 0, 0, 0, 0, 0); settle;
        chk_out("flush_end", 0, 0, 0, 0, 2'd0); tick;

        // Second redirect during first flush cycle extends to three
        ex_redirect = 1'b1; settle;
        chk_out("rr_a", 0, 0, 0, 0, 2'd0); tick;
        settle;
        chk_out("rr_b", 0, 1, 1, 1, 2'd0); tick;
        ex_redirect = 1'b0; settle;
        chk_out("rr_c", 0, 1, 1, 1, 2'd0); tick;
        settle;
        chk_out("rr_d", 0, 1, 1, 1, 2'd0); tick;

        // Reset during flush with two pending writes to x7
        set_id(1, 0, 0, 0, 0, 5'd7, 1, 0); settle;
        chk_out("x7_a", 1, 0, 0, 0, 2'd0); tick;
        settle;
        chk_out("x7_b", 1, 0, 0, 0, 2'd1); tick;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        ex_redirect = 1'b1; settle;
        chk_out("x7_redir", 0, 0, 0, 0, 2'd2); tick;
        ex_redirect = 1'b0; settle;
        chk_out("x7_flush", 0, 1, 1, 1, 2'd2);
        reset = 1'b1; tick;
        reset = 1'b0;
        set_id(1, 5'd7, 1, 0, 0, 0, 0, 0); settle;
        chk_out("post_rst", 1, 0, 0, 0, 2'd0); tick;
        set_id(0, 0, 0, 0, 0, 0, 0, 0); settle;
        chk_out("post_iss", 0, 0, 0, 0, 2'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
